// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined processor: default widths,
// the NOP encoding used for pipeline bubbles, and the fetch FSM states.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_gen.sv
// Program counter register with next-PC selection:
// halt hold > taken branch > stall hold > jump > sequential increment.
module pc_gen
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_next;

  // A taken branch beats a stall: the stalled instruction is on the wrong path.
  always_comb begin
    pc_next = pc + ADDR_WIDTH'(1);
    if (halt)
      pc_next = pc;
    else if (branch_taken)
      pc_next = branch_target;
    else if (stall)
      pc_next = pc;
    else if (jump)
      pc_next = jump_addr;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= '0;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, IF/ID pipeline register,
// run/halt FSM driven by decoded Stop, and a valid-fetch counter.
module if_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_IF_i,
  input  logic                  stall_IF_ID_i,
  input  logic                  flush_IF_ID_i,
  input  logic                  Jump_i,
  input  logic [ADDR_WIDTH-1:0] jumpAddr_i,
  input  logic                  PCSrc_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  Stop_i,
  output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_mem_rD_i,
  output logic [ADDR_WIDTH-1:0] PCD_o,
  output logic [DATA_WIDTH-1:0] instruction_mem_rD_o,
  output logic                  validD_o,
  output logic                  halted_o,
  output logic [15:0]           fetch_count_o
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  squash;

  pc_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .halt         (state == HALT),
    .branch_taken (PCSrc_i),
    .branch_target(branch_target_i),
    .stall        (stall_IF_i),
    .jump         (Jump_i),
    .jump_addr    (jumpAddr_i),
    .pc           (pc)
  );

  assign instr_mem_addr_o = pc;

  // Wrong-path fetches behind a redirect are squashed here, not by the hazard unit.
  assign squash = flush_IF_ID_i | PCSrc_i | (Jump_i & ~stall_IF_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      PCD_o                <= '0;
      instruction_mem_rD_o <= DATA_WIDTH'(NOP_INSTR);
      validD_o             <= 1'b0;
      fetch_count_o        <= '0;
    end else if (squash || (!stall_IF_ID_i && state == HALT)) begin
      PCD_o                <= '0;
      instruction_mem_rD_o <= DATA_WIDTH'(NOP_INSTR);
      validD_o             <= 1'b0;
    end else if (!stall_IF_ID_i) begin
      PCD_o                <= pc;
      instruction_mem_rD_o <= instr_mem_rD_i;
      validD_o             <= 1'b1;
      fetch_count_o        <= fetch_count_o + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      halted_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A stalled Stop waits; one squashed by a branch or flush never halts.
          if (Stop_i && !PCSrc_i && !flush_IF_ID_i && !stall_IF_ID_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        HALT: begin
          state    <= HALT;
          halted_o <= 1'b1;
        end
        default: begin
          state    <= RUN;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized
// control inputs checked against a cycle-level behavioural model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_IF_i, stall_IF_ID_i, flush_IF_ID_i;
  logic        Jump_i, PCSrc_i, Stop_i;
  logic [7:0]  jumpAddr_i, branch_target_i;
  logic [7:0]  instr_mem_addr_o, PCD_o;
  logic [15:0] instr_mem_rD_i, instruction_mem_rD_o, fetch_count_o;
  logic        validD_o, halted_o;

  logic [15:0] mem [256];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Behavioural model of the architectural state visible at the outputs
  logic [7:0]  m_pc, m_pcd;
  logic [15:0] m_ins, m_count;
  logic        m_valid, m_halted;

  always #5 clk = ~clk;

  assign instr_mem_rD_i = mem[instr_mem_addr_o];

  if_stage #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_IF_i          (stall_IF_i),
    .stall_IF_ID_i       (stall_IF_ID_i),
    .flush_IF_ID_i       (flush_IF_ID_i),
    .Jump_i              (Jump_i),
    .jumpAddr_i          (jumpAddr_i),
    .PCSrc_i             (PCSrc_i),
    .branch_target_i     (branch_target_i),
    .Stop_i              (Stop_i),
    .instr_mem_addr_o    (instr_mem_addr_o),
    .instr_mem_rD_i      (instr_mem_rD_i),
    .PCD_o               (PCD_o),
    .instruction_mem_rD_o(instruction_mem_rD_o),
    .validD_o            (validD_o),
    .halted_o            (halted_o),
    .fetch_count_o       (fetch_count_o)
  );

  task automatic idle_inputs();
    rst = 1'b0; stall_IF_i = 1'b0; stall_IF_ID_i = 1'b0; flush_IF_ID_i = 1'b0;
    Jump_i = 1'b0; PCSrc_i = 1'b0; Stop_i = 1'b0;
    jumpAddr_i = '0; branch_target_i = '0;
  endtask

  // Advance model by one clock from current inputs, then let the DUT clock and settle.
  task automatic tick();
    logic [7:0] npc;
    logic       nhalt;
    if (rst) begin
      npc = 8'h00; nhalt = 1'b0;
      m_pcd = 8'h00; m_ins = 16'h0000; m_valid = 1'b0; m_count = 16'h0000;
    end else begin
      if (m_halted)          npc = m_pc;
      else if (PCSrc_i)      npc = branch_target_i;
      else if (stall_IF_i)   npc = m_pc;
      else if (Jump_i)       npc = jumpAddr_i;
      else                   npc = m_pc + 8'd1;
      nhalt = m_halted | (Stop_i & ~PCSrc_i & ~flush_IF_ID_i & ~stall_IF_ID_i);
      if (flush_IF_ID_i || PCSrc_i || (Jump_i && !stall_IF_i) ||
          (!stall_IF_ID_i && m_halted)) begin
        m_pcd = 8'h00; m_ins = 16'h0000; m_valid = 1'b0;
      end else if (!stall_IF_ID_i) begin
        m_pcd = m_pc; m_ins = mem[m_pc]; m_valid = 1'b1; m_count = m_count + 16'd1;
      end
    end
    m_pc = npc;
    m_halted = nhalt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o} !==
        {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL reset: addr=%h pcd=%h ins=%h v=%b h=%b cnt=%0d required all zero",
               instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o, instr_mem_addr_o} !==
          {8'(i), 16'h1000 + 16'(i), 1'b1, 16'(i + 1), 8'(i + 1)}) begin
        n_err++;
        $display("FAIL seq_fetch%0d: pcd=%h ins=%h v=%b cnt=%0d addr=%h required pcd=%h ins=%h v=1 cnt=%0d addr=%h",
                 i, PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o, instr_mem_addr_o,
                 8'(i), 16'h1000 + 16'(i), i + 1, 8'(i + 1));
      end
    end
  endtask

  task automatic test_jump();
    tick();  // PC 4 -> 5
    Jump_i = 1'b1; jumpAddr_i = 8'h40;
    tick();
    n_cmp++;
    if ({validD_o, instr_mem_addr_o, fetch_count_o} !== {1'b0, 8'h40, 16'd5}) begin
      n_err++;
      $display("FAIL jump_bubble: v=%b addr=%h cnt=%0d required v=0 addr=40 cnt=5",
               validD_o, instr_mem_addr_o, fetch_count_o);
    end
    Jump_i = 1'b0;
    tick();
    n_cmp++;
    if ({PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o} !== {8'h40, 16'h1040, 1'b1, 16'd6}) begin
      n_err++;
      $display("FAIL jump_target: pcd=%h ins=%h v=%b cnt=%0d required pcd=40 ins=1040 v=1 cnt=6",
               PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o);
    end
  endtask

  task automatic test_branch_priority();
    PCSrc_i = 1'b1; branch_target_i = 8'h10; stall_IF_i = 1'b1;
    Jump_i = 1'b1; jumpAddr_i = 8'h55; Stop_i = 1'b1;
    tick();
    n_cmp++;
    if ({instr_mem_addr_o, validD_o, halted_o} !== {8'h10, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL branch_priority: addr=%h v=%b h=%b required addr=10 v=0 h=0",
               instr_mem_addr_o, validD_o, halted_o);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [15:0] cnt0;
    Jump_i = 1'b1; jumpAddr_i = 8'h06;
    tick();
    Jump_i = 1'b0;
    tick();  // IF/ID holds PC 6, PC = 7
    cnt0 = m_count;
    stall_IF_i = 1'b1; stall_IF_ID_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o} !==
          {8'h07, 8'h06, 16'h1006, 1'b1, cnt0}) begin
        n_err++;
        $display("FAIL stall_hold%0d: addr=%h pcd=%h ins=%h v=%b cnt=%0d required addr=07 pcd=06 ins=1006 v=1 cnt=%0d",
                 i, instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, fetch_count_o, cnt0);
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({PCD_o, instruction_mem_rD_o, instr_mem_addr_o, fetch_count_o} !==
        {8'h07, 16'h1007, 8'h08, cnt0 + 16'd1}) begin
      n_err++;
      $display("FAIL stall_resume: pcd=%h ins=%h addr=%h cnt=%0d required pcd=07 ins=1007 addr=08 cnt=%0d",
               PCD_o, instruction_mem_rD_o, instr_mem_addr_o, fetch_count_o, cnt0 + 16'd1);
    end
  endtask

  task automatic test_wrap();
    Jump_i = 1'b1; jumpAddr_i = 8'hFF;
    tick();
    Jump_i = 1'b0;
    tick();
    n_cmp++;
    if ({instr_mem_addr_o, PCD_o, instruction_mem_rD_o} !== {8'h00, 8'hFF, 16'h10FF}) begin
      n_err++;
      $display("FAIL pc_wrap: addr=%h pcd=%h ins=%h required addr=00 pcd=ff ins=10ff",
               instr_mem_addr_o, PCD_o, instruction_mem_rD_o);
    end
  endtask

  task automatic test_halt();
    logic [7:0] pc0;
    Stop_i = 1'b1;
    tick();
    Stop_i = 1'b0;
    pc0 = instr_mem_addr_o;
    n_cmp++;
    if (halted_o !== 1'b1) begin
      n_err++;
      $display("FAIL halt_rise: halted=%b required 1", halted_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({instr_mem_addr_o, validD_o, halted_o} !== {pc0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL halt_frozen%0d: addr=%h v=%b h=%b required addr=%h v=0 h=1",
                 i, instr_mem_addr_o, validD_o, halted_o, pc0);
      end
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o} !==
        {8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
      n_err++;
      $display("FAIL halt_reset: addr=%h pcd=%h ins=%h v=%b h=%b cnt=%0d required all zero",
               instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({PCD_o, validD_o, instr_mem_addr_o} !== {8'h00, 1'b1, 8'h01}) begin
      n_err++;
      $display("FAIL halt_restart: pcd=%h v=%b addr=%h required pcd=00 v=1 addr=01",
               PCD_o, validD_o, instr_mem_addr_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      stall_IF_i      = ($urandom_range(0, 5) == 0);
      stall_IF_ID_i   = ($urandom_range(0, 5) == 0);
      flush_IF_ID_i   = ($urandom_range(0, 9) == 0);
      Jump_i          = ($urandom_range(0, 7) == 0);
      PCSrc_i         = ($urandom_range(0, 7) == 0);
      Stop_i          = ($urandom_range(0, 29) == 0);
      jumpAddr_i      = 8'($urandom);
      branch_target_i = 8'($urandom);
      tick();
      n_cmp++;
      if ({instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o} !==
          {m_pc, m_pcd, m_ins, m_valid, m_halted, m_count}) begin
        n_err++;
        $display("FAIL random%0d: addr=%h pcd=%h ins=%h v=%b h=%b cnt=%0d required addr=%h pcd=%h ins=%h v=%b h=%b cnt=%0d",
                 i, instr_mem_addr_o, PCD_o, instruction_mem_rD_o, validD_o, halted_o, fetch_count_o,
                 m_pc, m_pcd, m_ins, m_valid, m_halted, m_count);
      end
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    m_pc = '0; m_pcd = '0; m_ins = '0; m_valid = 1'b0; m_halted = 1'b0; m_count = '0;
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_jump();
    test_branch_priority();
    test_stall();
    test_wrap();
    test_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
